serial_addsub: RTL
==================

# serial_addsub

Parametrised multi-cycle adder/subtractor that extends the 4-bit ripple subtractor to WIDTH bits. Each clock it processes one CHUNK-bit slice with a registered carry/borrow, so the slice logic stays CHUNK bits deep at any WIDTH. It runs a start/busy/done handshake and reports carry/borrow, signed overflow and zero flags. It sits in the datapath beside the combinational sub4/full_sub blocks, wherever wide operands are needed at a high clock rate.

## Interface
- WIDTH, 16: operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (derived, not overridable): WIDTH/CHUNK.

Ports (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only while busy=0.
- mode  input  1  0 = subtract (a - b - ci), 1 = add (a + b + ci).
- a  input  WIDTH  minuend or first addend, unsigned/two's complement.
- b  input  WIDTH  subtrahend or second addend.
- ci  input  1  borrow-in (subtract) or carry-in (add).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the results update.
- s  output  WIDTH  result.
- co  output  1  borrow-out (subtract) or carry-out (add).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  1 when s == 0.

## Operation
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE with start=1 at an edge:
  - capture a, b, mode and ci into internal registers;
  - load the carry/borrow register with ci and set the slice index to 0;
  - go to RUN.
- IDLE with start=0: hold.
- RUN, each edge:
  - compute slice idx, bits [idx*CHUNK +: CHUNK], from the captured operands and the carry/borrow register;
  - write the slice into the internal accumulator;
  - update the carry/borrow register;
  - increment idx.
- Subtract slice: d = a_slice - b_slice - borrow. Borrow-out = 1 when a_slice < b_slice + borrow (unsigned).
- Add slice: d = a_slice + b_slice + carry. Carry-out is bit CHUNK of the (CHUNK+1)-bit sum.
- Last slice (idx = NCHUNK-1), on the same edge:
  - publish the full accumulator to s and the final carry/borrow to co;
  - ovf: add = (a_msb == b_msb) && (s_msb != a_msb); subtract = (a_msb != b_msb) && (s_msb != a_msb);
  - zero = (s == 0);
  - set done=1 and return to IDLE.
- Result arithmetic is modulo 2^WIDTH. Full result equals a ± b ± ci.
- s, co, ovf and zero hold their last published values until the next completion. They never show partial slices.
- start while busy=1 is ignored and does not queue. Input changes during RUN have no effect.
- CHUNK = WIDTH degenerates to NCHUNK=1: a single RUN cycle.

## Timing
- Reset (async assert, any time, including mid-RUN):
  - busy=0, done=0, s=0, co=0, ovf=0, zero=0;
  - state IDLE, idx=0, carry register 0;
  - any in-flight operation is discarded with no done pulse.
- Latency: start sampled at edge T0. busy=1 after T0. Slices are computed at edges T1..TNCHUNK.
- After edge TNCHUNK: results valid, done=1 for exactly one cycle, busy=0.
- Back-to-back: start held high during the done cycle is accepted at edge TNCHUNK+1. Throughput is one operation per NCHUNK+1 cycles.
- done and busy are never 1 in the same cycle.

## Test plan (WIDTH=16, CHUNK=4)
- Subtract, basic: mode=0, a=0x1234, b=0x0234, ci=0, start 1 cycle -> busy high 4 cycles, then done pulse; s=0x1000, co=0, ovf=0, zero=0.
- Subtract, borrow and ci: a=0x0000, b=0x0001, ci=0 -> s=0xFFFF, co=1, ovf=0. Then a=0x0005, b=0x0005, ci=1 -> s=0xFFFF, co=1.
- Signed overflow: subtract 0x8000-0x0001 -> s=0x7FFF, ovf=1, co=0. Add 0x7FFF+0x0001 -> s=0x8000, ovf=1, co=0.
- Add wrap-around: mode=1, a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, zero=1, ovf=0.
- Handshake:
  - start pulsed while busy with different operands -> ignored; first result only.
  - start held high continuously -> done every 5 cycles.
  - operands changed mid-RUN -> result unaffected.
- Reset and parameter sweep:
  - rst asserted at RUN slice 2 -> all outputs 0 immediately, no done pulse; the next operation completes correctly.
  - repeat the random-vs-reference sweep with CHUNK=1, 8 and 16.

Source files
------------

// File: rtl/serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock with a registered
// carry/borrow, start/busy/done handshake, and carry, overflow and zero flags.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode;
    logic             r_cy;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_zero;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_d;
    logic             w_cy_nxt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Bit CHUNK is the carry for add, and the sign (i.e. borrow) for subtract.
    function automatic logic [CHUNK:0] slice_op(input logic add, input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y, input logic c);
        logic [CHUNK:0] r;
        if (add) r = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
        else     r = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, c};
        return r;
    endfunction

    function automatic logic ovf_of(input logic add, input logic am, input logic bm,
                                    input logic sm);
        return add ? ((am == bm) && (sm != am)) : ((am != bm) && (sm != am));
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Current slice merged into the accumulator, so the last edge can publish it whole.
    always_comb begin
        w_a_sl             = r_a[r_idx*CHUNK +: CHUNK];
        w_b_sl             = r_b[r_idx*CHUNK +: CHUNK];
        {w_cy_nxt, w_d}    = slice_op(r_mode, w_a_sl, w_b_sl, r_cy);
        w_res              = r_acc;
        w_res[r_idx*CHUNK +: CHUNK] = w_d;
        w_ovf              = ovf_of(r_mode, r_a[WIDTH-1], r_b[WIDTH-1], w_res[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cy    <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_load) begin
                r_cy  <= ci;
                r_idx <= '0;
            end else if (w_step) begin
                r_cy  <= w_cy_nxt;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_last) begin
                r_s    <= w_res;
                r_co   <= w_cy_nxt;
                r_ovf  <= w_ovf;
                r_zero <= (w_res == '0);
            end
        end
    end

    // Operand and accumulator storage needs no reset: only read while in RUN.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
        end
        if (w_step) r_acc <= w_res;
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
